fft_sdf_stage_buffer: RTL

Parametrised block-parallel radix-2 decimation-in-frequency butterfly stage for the 512-point FFT datapath. Accepts BLK_SIZE complex samples per beat and pairs elements DIST apart within each group of 2·DIST elements. It emits sums immediately and buffers differences for later output. One shared buffer serves both directions, and the frame length, span, widths, scaling and pipeline depth are generic. A single instance can serve any stage whose span is at least BLK_SIZE. Pad-free streaming: consecutive groups overlap. A drain phase is entered only at frame end.

---
 rtl/fft_sdf_stage_buffer_if.sv | 13 +
 rtl/fft_sdf_stage_buffer.sv | 119 +++++++++++
 2 files changed

// File: rtl/fft_sdf_stage_buffer_if.sv
// fft_sdf_stage_buffer_if: input/output beat bundle of the radix-2 SDF butterfly stage
interface fft_sdf_stage_buffer_if #(
   parameter int BLK_SIZE  = 16,
   parameter int IN_WIDTH  = 9,
   parameter int OUT_WIDTH = 10
);
   logic [BLK_SIZE*IN_WIDTH-1:0]  din_i, din_q;
   logic                          i_valid, in_ready;
   logic [BLK_SIZE*OUT_WIDTH-1:0] dout_i, dout_q;
   logic                          o_valid, o_sop, o_eop;
   modport master (output din_i, din_q, i_valid, input in_ready, dout_i, dout_q, o_valid, o_sop, o_eop);
   modport slave  (input din_i, din_q, i_valid, output in_ready, dout_i, dout_q, o_valid, o_sop, o_eop);
endinterface

// File: rtl/fft_sdf_stage_buffer.sv
// fft_sdf_stage_buffer: block-parallel radix-2 DIF butterfly stage sharing one buffer for first halves and diffs
module fft_sdf_stage_buffer #(
   parameter int IN_WIDTH   = 9,
   parameter int OUT_WIDTH  = 10,
   parameter int N_POINTS   = 512,
   parameter int DIST       = 256,
   parameter int BLK_SIZE   = 16,
   parameter int SCALE      = 0,
   parameter int PIPE_DEPTH = 0
) (
   input logic clk,
   input logic rst,
   fft_sdf_stage_buffer_if.slave s
);
   localparam int W  = DIST / BLK_SIZE;
   localparam int G  = N_POINTS / (2 * DIST);
   localparam int KW = W > 1 ? $clog2(W) : 1;
   localparam int GW = G > 1 ? $clog2(G) : 1;
   localparam int EW = IN_WIDTH + 1;
   localparam int L  = 2 * BLK_SIZE;
   typedef enum logic [1:0] {FILL, PAIR, DRAIN} state_t;
   state_t                 r_state, w_state;
   logic [KW-1:0]          r_k, w_k;
   logic [GW-1:0]          r_g, w_g;
   logic                   r_pend, w_pend, w_xfer, w_last, w_emit, w_sop, w_eop;
   logic [L*EW-1:0]        r_mem [W];
   logic [L*EW-1:0]        w_rd, w_wr;
   logic [L*IN_WIDTH-1:0]  w_din;
   logic [L*OUT_WIDTH-1:0] w_out;
   logic [L*OUT_WIDTH-1:0] r_dout [PIPE_DEPTH+1];
   logic [PIPE_DEPTH:0]    r_v, r_sop, r_eop;
   assign s.in_ready = !rst && r_state != DRAIN;
   assign w_xfer     = s.i_valid && s.in_ready;
   assign w_last     = r_k == KW'(W - 1);
   assign w_din      = {s.din_q, s.din_i};
   assign w_rd       = r_mem[r_k];
   assign w_emit     = r_state == DRAIN || (w_xfer && (r_state == PAIR || r_pend));
   assign w_sop      = w_xfer && r_state == PAIR && r_g == '0 && r_k == '0;
   assign w_eop      = r_state == DRAIN && w_last;
   always_comb begin
      w_state = r_state;
      w_k     = r_k;
      w_g     = r_g;
      w_pend  = r_pend;
      if (r_state == DRAIN || w_xfer) begin
         w_k = w_last ? '0 : r_k + 1'b1;
         if (w_last) begin
            if (r_state == FILL) begin
               w_state = PAIR;
               w_pend  = 1'b0;
            end else if (r_state == PAIR && r_g != GW'(G - 1)) begin
               w_state = FILL;
               w_g     = r_g + 1'b1;
               w_pend  = 1'b1;
            end else if (r_state == PAIR) begin
               w_state = DRAIN;
            end else begin
               w_state = FILL;
               w_g     = '0;
               w_pend  = 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
         r_k     <= '0;
         r_g     <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_k     <= w_k;
         r_g     <= w_g;
         r_pend  <= w_pend;
      end
   end
   // the word read this cycle is replaced by the first half (FILL) or the diff (PAIR)
   always_ff @(posedge clk)
      if (w_xfer) r_mem[r_k] <= w_wr;
   for (genvar j = 0; j < L; j++) begin : g_lane
      logic signed [EW-1:0] w_a, w_b, w_r;
      assign w_a = w_rd[j*EW +: EW];
      assign w_b = {w_din[j*IN_WIDTH+IN_WIDTH-1], w_din[j*IN_WIDTH +: IN_WIDTH]};
      assign w_r = r_state == PAIR ? w_a + w_b : w_a;
      assign w_wr[j*EW +: EW] = r_state == PAIR ? w_a - w_b : w_b;
      if (SCALE != 0) begin : g_scale
         logic signed [EW:0] w_t;
         assign w_t = $signed({w_r[EW-1], w_r} + {{EW{1'b0}}, 1'b1}) >>> 1;
         assign w_out[j*OUT_WIDTH +: OUT_WIDTH] = !w_t[EW] && (w_t[IN_WIDTH] || w_t[IN_WIDTH-1]) ?
                                                  {1'b0, {(OUT_WIDTH-1){1'b1}}} : w_t[OUT_WIDTH-1:0];
      end else begin : g_full
         assign w_out[j*OUT_WIDTH +: OUT_WIDTH] = w_r;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v   <= '0;
         r_sop <= '0;
         r_eop <= '0;
         for (int p = 0; p <= PIPE_DEPTH; p++) r_dout[p] <= '0;
      end else begin
         r_v[0]    <= w_emit;
         r_sop[0]  <= w_emit && w_sop;
         r_eop[0]  <= w_eop;
         r_dout[0] <= w_out;
         for (int p = 1; p <= PIPE_DEPTH; p++) begin
            r_v[p]    <= r_v[p-1];
            r_sop[p]  <= r_sop[p-1];
            r_eop[p]  <= r_eop[p-1];
            r_dout[p] <= r_dout[p-1];
         end
      end
   end
   assign {s.dout_q, s.dout_i} = r_dout[PIPE_DEPTH];
   assign s.o_valid = r_v[PIPE_DEPTH];
   assign s.o_sop   = r_sop[PIPE_DEPTH];
   assign s.o_eop   = r_eop[PIPE_DEPTH];
endmodule
